// File: rtl/vc_fifo.sv
// Multi-VC flit buffer: NUM_VC independent FIFOs in shared storage, per-VC status and credit return.
// Latency: write-to-status 1 cycle; read data, rvalid and credit 1 cycle after the accepting edge.
// Backpressure: writes to a full VC pulse ovf and reads of an empty VC pulse udf; neither changes any state.
module vc_fifo #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int NUM_VC       = 2,
  parameter int AFULL_THRESH = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [VW-1:0]              wvc,
  input  logic                       winc,
  input  logic                       rinc,
  input  logic [VW-1:0]              rvc,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic [NUM_VC-1:0]          wfull,
  output logic [NUM_VC-1:0]          rempty,
  output logic [NUM_VC-1:0]          walmost_full,
  output logic [NUM_VC*(AW+1)-1:0]   count,
  output logic                       credit,
  output logic [VW-1:0]              credit_vc,
  output logic                       ovf,
  output logic                       udf
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] full_lvl  = CW'(DEPTH);
  localparam logic [CW-1:0] afull_lvl = CW'(AFULL_THRESH);
  localparam logic [VW:0]   vc_lim    = (VW+1)'(NUM_VC);

  // Shared flit storage, word address {vc, ptr}; contents are not reset.
  logic [WIDTH-1:0] mem [NUM_VC*DEPTH];

  logic [AW-1:0] wptr [NUM_VC];
  logic [AW-1:0] rptr [NUM_VC];
  logic [CW-1:0] cnt  [NUM_VC];

  logic              wvc_ok, rvc_ok;
  logic              wacc, racc;
  logic [NUM_VC-1:0] wsel, rsel;

  // An index beyond NUM_VC (non-power-of-2 channel counts) is never accepted.
  assign wvc_ok = ({1'b0, wvc} < vc_lim);
  assign rvc_ok = ({1'b0, rvc} < vc_lim);

  // Acceptance looks only at registered status, so a same-cycle read never frees room for a write and vice versa.
  assign wacc = winc && wvc_ok && !wfull[wvc];
  assign racc = rinc && rvc_ok && !rempty[rvc];

  // Per-VC status decoded from the registered counts; no input reaches these outputs.
  always_comb begin
    wfull        = '0;
    rempty       = '0;
    walmost_full = '0;
    count        = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wfull[v]          = (cnt[v] == full_lvl);
      rempty[v]         = (cnt[v] == '0);
      walmost_full[v]   = (cnt[v] >= afull_lvl);
      count[v*CW +: CW] = cnt[v];
    end
  end

  // One-hot per-VC select of the accepted write and read.
  always_comb begin
    wsel = '0;
    rsel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wsel[v] = wacc && (wvc == VW'(v));
      rsel[v] = racc && (rvc == VW'(v));
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous accepted read and write on one VC leaves its count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wptr[v] <= '0;
        rptr[v] <= '0;
        cnt[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wsel[v]) wptr[v] <= wptr[v] + 1'b1;
        if (rsel[v]) rptr[v] <= rptr[v] + 1'b1;
        if (wsel[v] && !rsel[v])
          cnt[v] <= cnt[v] + 1'b1;
        else if (rsel[v] && !wsel[v])
          cnt[v] <= cnt[v] - 1'b1;
      end
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wacc) mem[{wvc, wptr[wvc]}] <= wdata;
  end

  // Registered read data, credit return and reject pulses; rdata holds across idle or rejected cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata     <= '0;
      rvalid    <= 1'b0;
      credit    <= 1'b0;
      credit_vc <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      rvalid <= racc;
      credit <= racc;
      ovf    <= winc && !wacc;
      udf    <= rinc && !racc;
      if (racc) begin
        rdata     <= mem[{rvc, rptr[rvc]}];
        credit_vc <= rvc;
      end
    end
  end

endmodule
